// File: rtl/text_console_writer_pkg.sv
//------------------------------------------------------------------------------
// Module   : text_console_writer_pkg
// Purpose  : Screen layout, fill code, control codes and FSM states shared by
//            the console writer and the OSD text renderer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package text_console_writer_pkg;

  localparam int          c_cols   = 40;
  localparam int          c_rows   = 30;
  localparam int          c_addr_w = 11;
  localparam logic [7:0]  c_blank  = 8'h20;

  localparam logic [7:0]  c_cr     = 8'h0D;
  localparam logic [7:0]  c_lf     = 8'h0A;
  localparam logic [7:0]  c_bs     = 8'h08;
  localparam logic [7:0]  c_ff     = 8'h0C;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_SCROLL_FILL
  } state_t;

  function automatic logic is_printable(input logic [7:0] code);
    return code >= 8'h20;
  endfunction

endpackage

`default_nettype wire

// File: rtl/text_console_writer.sv
//------------------------------------------------------------------------------
// Module   : text_console_writer
// Purpose  : Byte-stream writer into the dual-port OSD text RAM with cursor,
//            wrap, control codes, clear-screen and in-RAM scroll-up.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int         COLS   = c_cols,
  parameter int         ROWS   = c_rows,
  parameter int         ADDR_W = c_addr_w,
  parameter logic [7:0] BLANK  = c_blank
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char_data,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] c_one_a     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_cols_a    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] c_last_cell = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] c_last_copy = ADDR_W'((ROWS-1)*COLS-1);
  localparam logic [ADDR_W-1:0] c_fill_base = ADDR_W'((ROWS-1)*COLS);
  localparam logic [ADDR_W-1:0] c_last_fill = ADDR_W'(COLS-1);
  localparam logic [5:0]        c_last_col  = 6'(COLS-1);
  localparam logic [4:0]        c_last_row  = 5'(ROWS-1);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
  logic [5:0]          r_col, w_col_nxt;
  logic [4:0]          r_row, w_row_nxt;
  logic                r_pend, w_pend_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [7:0]          r_wdata, w_wdata_nxt;
  logic [ADDR_W-1:0]   w_row_ext, w_row_base, w_wr_addr;
  logic                w_xfer;

  assign w_row_ext = ADDR_W'(r_row);

  generate
    if (COLS == 40) begin : g_row_shift
      assign w_row_base = (w_row_ext << 5) + (w_row_ext << 3);
    end else begin : g_row_mult
      assign w_row_base = w_row_ext * c_cols_a;
    end
  endgenerate

  assign w_wr_addr  = w_row_base + ADDR_W'(r_col);
  assign char_ready = (r_state == ST_IDLE) || ((r_state == ST_WRITE) && !r_pend);
  assign w_xfer     = char_valid && char_ready;
  assign busy       = (r_state == ST_CLEAR) || (r_state == ST_SCROLL_RD) ||
                      (r_state == ST_SCROLL_WR) || (r_state == ST_SCROLL_FILL);

  // The copy write data comes straight from the RAM read port, which is
  // valid during SCROLL_WR for the address presented during SCROLL_RD.
  assign ram_wdata  = (r_state == ST_SCROLL_WR) ? ram_rdata : r_wdata;
  assign ram_addr   = r_addr;
  assign ram_we     = r_we;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_pend  <= w_pend_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_pend_nxt  = r_pend;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    case (r_state)
      ST_CLEAR: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = r_idx;
        w_wdata_nxt = BLANK;
        if (r_idx == c_last_cell) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt   = r_idx + c_one_a;
        end
      end
      ST_IDLE, ST_WRITE: begin
        if ((r_state == ST_WRITE) && r_pend) begin
          // Wrap off the last row: the character is out, now scroll.
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_SCROLL_RD;
          w_idx_nxt   = '0;
          w_addr_nxt  = c_cols_a;
        end else begin
          w_state_nxt = ST_IDLE;
          if (w_xfer) begin
            if (is_printable(char_data)) begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = w_wr_addr;
              w_wdata_nxt = char_data;
              w_state_nxt = ST_WRITE;
              if (r_col == c_last_col) begin
                w_col_nxt = '0;
                if (r_row == c_last_row) w_pend_nxt = 1'b1;
                else                     w_row_nxt  = r_row + 5'd1;
              end else begin
                w_col_nxt = r_col + 6'd1;
              end
            end else begin
              case (char_data)
                c_cr: w_col_nxt = '0;
                c_lf: begin
                  if (r_row == c_last_row) begin
                    w_state_nxt = ST_SCROLL_RD;
                    w_idx_nxt   = '0;
                    w_addr_nxt  = c_cols_a;
                  end else begin
                    w_row_nxt = r_row + 5'd1;
                  end
                end
                c_bs: if (r_col != '0) w_col_nxt = r_col - 6'd1;
                c_ff: begin
                  w_state_nxt = ST_CLEAR;
                  w_idx_nxt   = '0;
                  w_col_nxt   = '0;
                  w_row_nxt   = '0;
                end
                default: ;
              endcase
            end
          end
        end
      end
      ST_SCROLL_RD: begin
        w_state_nxt = ST_SCROLL_WR;
        w_addr_nxt  = r_idx;
        w_we_nxt    = 1'b1;
      end
      ST_SCROLL_WR: begin
        if (r_idx == c_last_copy) begin
          w_state_nxt = ST_SCROLL_FILL;
          w_idx_nxt   = '0;
          w_addr_nxt  = c_fill_base;
          w_we_nxt    = 1'b1;
          w_wdata_nxt = BLANK;
        end else begin
          w_state_nxt = ST_SCROLL_RD;
          w_idx_nxt   = r_idx + c_one_a;
          w_addr_nxt  = r_idx + c_one_a + c_cols_a;
        end
      end
      ST_SCROLL_FILL: begin
        if (r_idx == c_last_fill) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt   = r_idx + c_one_a;
          w_addr_nxt  = c_fill_base + r_idx + c_one_a;
          w_we_nxt    = 1'b1;
          w_wdata_nxt = BLANK;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire
